// File: rtl/fft_frame_collector.sv
// Ping-pong frame collector for the FFT/IFFT output stream: captures N-sample frames
// (optionally un-bit-reversing them) and replays each over a valid/ready interface.
module fft_frame_collector #(
  parameter int N      = 1024,
  parameter int LOG2N  = 10,
  parameter int DW     = 24,
  parameter bit BITREV = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  input  logic          in_sof,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          overflow,
  output logic          sync_err
);

  typedef enum logic [1:0] {RdIdle, RdPrime, RdStream} rdState_t;

  localparam logic [LOG2N-1:0] LastIdx = LOG2N'(N - 1);

  function automatic logic [LOG2N-1:0] bitRev(input logic [LOG2N-1:0] idx);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int b = 0; b < LOG2N; b++) begin
      r[b] = idx[LOG2N-1-b];
    end
    return r;
  endfunction

  // Both banks live in one RAM; the top address bit selects the bank.
  logic [DW-1:0]    mem [0:2*N-1];
  logic [DW-1:0]    ramQ;
  logic             wrEn;
  logic [LOG2N:0]   wrAddr;
  logic             rdEn;
  logic [LOG2N:0]   rdAddr;

  logic [LOG2N-1:0] wrIdx_q, wrIdx_d;
  logic             wrBank_q, wrBank_d;
  logic [1:0]       full_q, full_d;
  logic             dropping_q, dropping_d;
  logic             overflow_q, overflow_d;
  logic             syncErr_q, syncErr_d;
  logic [LOG2N-1:0] wrIdxEff;
  logic             frameDone;

  rdState_t         rdState_q, rdState_d;
  logic             rdBank_q, rdBank_d;
  logic [LOG2N-1:0] outIdx_q, outIdx_d;
  logic [DW-1:0]    outData_q, outData_d;
  logic             outValid_q, outValid_d;
  logic             outLast_q, outLast_d;
  logic             clearFull;
  logic             rdBankSel;
  logic [LOG2N-1:0] rdIdx;
  logic [LOG2N-1:0] nextOutIdx;

  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrAddr] <= in_data;
    end
    if (rdEn) begin
      ramQ <= mem[rdAddr];
    end
  end

  // An in_sof always restarts at index 0; after an overflow only an in_sof into a free bank resumes capture.
  always_comb begin
    wrIdx_d    = wrIdx_q;
    wrBank_d   = wrBank_q;
    dropping_d = dropping_q;
    overflow_d = overflow_q;
    syncErr_d  = 1'b0;
    wrEn       = 1'b0;
    wrIdxEff   = wrIdx_q;
    frameDone  = 1'b0;

    if (in_valid) begin
      if (dropping_q) begin
        if (in_sof && !full_q[wrBank_q]) begin
          wrEn       = 1'b1;
          wrIdxEff   = '0;
          dropping_d = 1'b0;
        end
      end else begin
        if (in_sof) begin
          wrIdxEff = '0;
        end
        if (in_sof && (wrIdx_q != '0)) begin
          syncErr_d = 1'b1;
        end
        if ((wrIdxEff == '0) && full_q[wrBank_q]) begin
          overflow_d = 1'b1;
          dropping_d = 1'b1;
        end else begin
          wrEn = 1'b1;
        end
      end

      if (wrEn) begin
        if (wrIdxEff == LastIdx) begin
          frameDone = 1'b1;
          wrBank_d  = ~wrBank_q;
          wrIdx_d   = '0;
        end else begin
          wrIdx_d = wrIdxEff + 1'b1;
        end
      end
    end

    wrAddr = {wrBank_q, (BITREV ? bitRev(wrIdxEff) : wrIdxEff)};
  end

  // The writer only sets flags of the bank it fills and the reader only clears the bank it drains.
  always_comb begin
    full_d = full_q;
    if (clearFull) begin
      full_d[rdBank_q] = 1'b0;
    end
    if (frameDone) begin
      full_d[wrBank_q] = 1'b1;
    end
  end

  assign nextOutIdx = outIdx_q + 1'b1;

  // ramQ always holds the word after the one in outData_q, so a transfer never stalls the stream.
  always_comb begin
    rdState_d  = rdState_q;
    rdBank_d   = rdBank_q;
    outIdx_d   = outIdx_q;
    outData_d  = outData_q;
    outValid_d = outValid_q;
    outLast_d  = outLast_q;
    rdEn       = 1'b0;
    rdBankSel  = rdBank_q;
    rdIdx      = '0;
    clearFull  = 1'b0;

    case (rdState_q)
      RdIdle: begin
        if (full_q[rdBank_q]) begin
          rdEn      = 1'b1;
          rdState_d = RdPrime;
        end
      end
      RdPrime: begin
        outData_d  = ramQ;
        outValid_d = 1'b1;
        outLast_d  = (LastIdx == '0);
        outIdx_d   = '0;
        rdState_d  = RdStream;
        if (LastIdx != '0) begin
          rdEn  = 1'b1;
          rdIdx = LOG2N'(1);
        end
      end
      RdStream: begin
        if (outValid_q && out_ready) begin
          if (outIdx_q == LastIdx) begin
            clearFull  = 1'b1;
            rdBank_d   = ~rdBank_q;
            outValid_d = 1'b0;
            outLast_d  = 1'b0;
            if (full_q[~rdBank_q]) begin
              rdEn      = 1'b1;
              rdBankSel = ~rdBank_q;
              rdState_d = RdPrime;
            end else begin
              rdState_d = RdIdle;
            end
          end else begin
            outData_d = ramQ;
            outIdx_d  = nextOutIdx;
            outLast_d = (nextOutIdx == LastIdx);
            if (nextOutIdx != LastIdx) begin
              rdEn  = 1'b1;
              rdIdx = nextOutIdx + 1'b1;
            end
          end
        end
      end
      default: begin
        rdState_d = RdIdle;
      end
    endcase

    rdAddr = {rdBankSel, rdIdx};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wrIdx_q    <= '0;
      wrBank_q   <= 1'b0;
      full_q     <= '0;
      dropping_q <= 1'b0;
      overflow_q <= 1'b0;
      syncErr_q  <= 1'b0;
      rdState_q  <= RdIdle;
      rdBank_q   <= 1'b0;
      outIdx_q   <= '0;
      outData_q  <= '0;
      outValid_q <= 1'b0;
      outLast_q  <= 1'b0;
    end else begin
      wrIdx_q    <= wrIdx_d;
      wrBank_q   <= wrBank_d;
      full_q     <= full_d;
      dropping_q <= dropping_d;
      overflow_q <= overflow_d;
      syncErr_q  <= syncErr_d;
      rdState_q  <= rdState_d;
      rdBank_q   <= rdBank_d;
      outIdx_q   <= outIdx_d;
      outData_q  <= outData_d;
      outValid_q <= outValid_d;
      outLast_q  <= outLast_d;
    end
  end

  assign out_data  = outData_q;
  assign out_valid = outValid_q;
  assign out_last  = outLast_q;
  assign overflow  = overflow_q;
  assign sync_err  = syncErr_q;

endmodule

// File: tb/tb_fft_frame_collector.sv
// Drives a natural-order and a bit-reversed collector with the same stream and
// checks every replayed frame against a ramp model.
module tb_fft_frame_collector;

  localparam int N     = 1024;
  localparam int LOG2N = 10;
  localparam int DW    = 24;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] inData;
  logic          inValid;
  logic          inSof;
  logic          outReady;

  logic [DW-1:0] natData, revData;
  logic          natValid, revValid, natLast, revLast;
  logic          natOvf, revOvf, natSync, revSync;

  int total = 0;
  int bad = 0;
  int syncCnt = 0;
  bit randReady = 1'b0;

  logic [DW-1:0] natQ[$];
  logic [DW-1:0] revQ[$];
  logic          natLastQ[$];
  logic          revLastQ[$];
  logic          prevStall = 1'b0;
  logic [DW-1:0] prevNat, prevRev;

  logic [DW-1:0] capNat [0:N-1];
  logic [DW-1:0] capRev [0:N-1];
  logic          capLast [0:N-1];

  typedef struct {
    int          idx;
    logic [23:0] expNat;
    logic [23:0] expRev;
    logic        expLast;
  } spot_t;
  spot_t spotTab[8];

  always #5 clk = ~clk;

  fft_frame_collector #(.N(N), .LOG2N(LOG2N), .DW(DW), .BITREV(1'b0)) dutNat (
    .clk(clk), .reset(reset), .in_data(inData), .in_valid(inValid), .in_sof(inSof),
    .out_data(natData), .out_valid(natValid), .out_ready(outReady), .out_last(natLast),
    .overflow(natOvf), .sync_err(natSync)
  );

  fft_frame_collector #(.N(N), .LOG2N(LOG2N), .DW(DW), .BITREV(1'b1)) dutRev (
    .clk(clk), .reset(reset), .in_data(inData), .in_valid(inValid), .in_sof(inSof),
    .out_data(revData), .out_valid(revValid), .out_ready(outReady), .out_last(revLast),
    .overflow(revOvf), .sync_err(revSync)
  );

  function automatic int tbBitRev(input int a);
    int r = 0;
    for (int b = 0; b < LOG2N; b++) begin
      if (a[b]) r = r | (1 << (LOG2N - 1 - b));
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic sof, input logic [DW-1:0] d);
    inValid = v;
    inSof   = sof;
    inData  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic sendFrame(input int base, input int len, input bit withSof);
    for (int k = 0; k < len; k++) begin
      applyStimulus(1'b1, withSof && (k == 0), DW'(base + k));
    end
    inValid = 1'b0;
    inSof   = 1'b0;
  endtask

  task automatic idle(input int n);
    inValid = 1'b0;
    inSof   = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitCount(input int n, input int budget, input string name);
    int c = 0;
    while (natQ.size() < n && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
    if (natQ.size() < n) checkOutput({name, " timeout"}, natQ.size(), n);
  endtask

  task automatic checkFrame(input string name, input int base);
    int eN = 0;
    int eR = 0;
    int eL = 0;
    logic lR;
    waitCount(N, 12000, name);
    if (natQ.size() >= N) begin
      for (int a = 0; a < N; a++) begin
        capNat[a]  = natQ.pop_front();
        capRev[a]  = revQ.pop_front();
        capLast[a] = natLastQ.pop_front();
        lR         = revLastQ.pop_front();
        if (capNat[a] !== DW'(base + a)) eN++;
        if (capRev[a] !== DW'(base + tbBitRev(a))) eR++;
        if (capLast[a] !== (a == N - 1) || lR !== (a == N - 1)) eL++;
      end
      checkOutput({name, " natural-order errors"}, eN, 0);
      checkOutput({name, " bit-reversed errors"}, eR, 0);
      checkOutput({name, " out_last errors"}, eL, 0);
    end
  endtask

  // Records every transfer and checks that a stalled word is held unchanged.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (prevStall) begin
        checkOutput("stall valid held", natValid, 1);
        checkOutput("stall nat data held", natData, prevNat);
        checkOutput("stall rev data held", revData, prevRev);
      end
      if (natValid && outReady) begin
        checkOutput("rev valid aligned", revValid, 1);
        natQ.push_back(natData);
        revQ.push_back(revData);
        natLastQ.push_back(natLast);
        revLastQ.push_back(revLast);
      end
      if (natSync === 1'b1) syncCnt++;
      prevStall = natValid && !outReady;
      prevNat   = natData;
      prevRev   = revData;
    end else begin
      prevStall = 1'b0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (randReady) outReady = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    spotTab[0] = '{0,    24'd0,    24'd0,    1'b0};
    spotTab[1] = '{1,    24'd1,    24'd512,  1'b0};
    spotTab[2] = '{2,    24'd2,    24'd256,  1'b0};
    spotTab[3] = '{3,    24'd3,    24'd768,  1'b0};
    spotTab[4] = '{6,    24'd6,    24'd384,  1'b0};
    spotTab[5] = '{511,  24'd511,  24'd1022, 1'b0};
    spotTab[6] = '{1022, 24'd1022, 24'd511,  1'b0};
    spotTab[7] = '{1023, 24'd1023, 24'd1023, 1'b1};

    reset    = 1'b0;
    inValid  = 1'b0;
    inSof    = 1'b0;
    inData   = '0;
    outReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("reset out_valid", natValid, 0);
    checkOutput("reset out_last", natLast, 0);
    checkOutput("reset out_data", natData, 0);
    checkOutput("reset overflow", natOvf, 0);
    checkOutput("reset sync_err", natSync, 0);
    checkOutput("reset rev out_valid", revValid, 0);

    $display("[TB] ramp frame, out_ready high");
    @(posedge clk);
    #1;
    sendFrame(0, N, 1'b1);
    @(negedge clk);
    checkOutput("latency valid after t", natValid, 0);
    @(negedge clk);
    checkOutput("latency valid after t+1", natValid, 0);
    @(negedge clk);
    checkOutput("latency valid after t+2", natValid, 1);
    checkOutput("latency rev valid after t+2", revValid, 1);
    checkOutput("first word", natData, 0);
    checkOutput("first word last", natLast, 0);
    @(posedge clk);
    #1;
    checkFrame("ramp", 0);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("spot nat[%0d]", spotTab[i].idx), capNat[spotTab[i].idx], spotTab[i].expNat);
      checkOutput($sformatf("spot rev[%0d]", spotTab[i].idx), capRev[spotTab[i].idx], spotTab[i].expRev);
      checkOutput($sformatf("spot last[%0d]", spotTab[i].idx), capLast[spotTab[i].idx], spotTab[i].expLast);
    end
    idle(20);
    checkOutput("ramp extra transfers", natQ.size(), 0);

    $display("[TB] random out_ready, three frames");
    randReady = 1'b1;
    sendFrame(1000, N, 1'b1);
    sendFrame(5000, N, 1'b0);
    waitCount(N, 12000, "rand f1 drain");
    sendFrame(9000, N, 1'b0);
    checkFrame("rand f1", 1000);
    checkFrame("rand f2", 5000);
    checkFrame("rand f3", 9000);
    randReady = 1'b0;
    outReady  = 1'b1;
    idle(20);
    checkOutput("rand extra transfers", natQ.size(), 0);
    checkOutput("rand overflow", natOvf, 0);
    checkOutput("rand rev overflow", revOvf, 0);

    $display("[TB] overflow with out_ready low");
    outReady = 1'b0;
    sendFrame(20000, N, 1'b1);
    sendFrame(30000, N, 1'b1);
    checkOutput("ovf before third frame", natOvf, 0);
    sendFrame(40000, N, 1'b1);
    sendFrame(45000, 10, 1'b0);
    @(negedge clk);
    checkOutput("ovf after third frame", natOvf, 1);
    checkOutput("ovf rev after third frame", revOvf, 1);
    checkOutput("ovf stalled valid", natValid, 1);
    checkOutput("ovf stalled word", natData, 20000);
    checkOutput("ovf no transfers", natQ.size(), 0);
    @(posedge clk);
    #1;
    outReady = 1'b1;
    checkFrame("ovf f1", 20000);
    checkFrame("ovf f2", 30000);
    idle(5);
    sendFrame(46000, 10, 1'b0);
    sendFrame(50000, N, 1'b1);
    checkFrame("ovf resume", 50000);
    idle(20);
    checkOutput("ovf extra transfers", natQ.size(), 0);
    checkOutput("ovf sticky", natOvf, 1);
    checkOutput("sync_err count before resync", syncCnt, 0);

    $display("[TB] in_sof mid-frame");
    sendFrame(60000, 300, 1'b1);
    applyStimulus(1'b1, 1'b1, DW'(70000));
    @(negedge clk);
    checkOutput("sync_err pulse", natSync, 1);
    checkOutput("sync_err rev pulse", revSync, 1);
    for (int k = 1; k < N; k++) begin
      applyStimulus(1'b1, 1'b0, DW'(70000 + k));
    end
    inValid = 1'b0;
    checkFrame("resync frame", 70000);
    idle(20);
    checkOutput("resync extra transfers", natQ.size(), 0);
    checkOutput("sync_err single pulse", syncCnt, 1);

    $display("[TB] reset mid-drain");
    sendFrame(80000, N, 1'b1);
    waitCount(500, 3000, "mid-drain");
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid reset out_valid", natValid, 0);
    checkOutput("mid reset out_last", natLast, 0);
    checkOutput("mid reset overflow", natOvf, 0);
    checkOutput("mid reset out_data", natData, 0);
    natQ.delete();
    revQ.delete();
    natLastQ.delete();
    revLastQ.delete();
    @(posedge clk);
    #1;
    sendFrame(90000, N, 1'b1);
    checkFrame("post-reset frame", 90000);
    idle(20);
    checkOutput("post-reset extra transfers", natQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
